// File: rtl/ball_motion.sv
// Purpose: squash-court ball engine; one position step per synchronised rising edge of tick_in.
// Latency: tick_in rise -> ball_x/ball_y/pulses/state registered 3 clk_in edges later.
// Backpressure: none; the update is unconditional, and ticks closer than 2 clk_in periods may be lost.
//
// Ports:
//   clk_in, rst (async active-low), tick_in (async game tick), serve (level, starts a rally),
//   paddle_x (paddle left edge) -> ball_x/ball_y (ball top-left), in_play (PLAY state),
//   hit_pulse/miss_pulse (1-cycle events), hit_count (rally hits, saturating).
module ball_motion #(
    parameter int H_RES     = 640,
    parameter int V_RES     = 480,
    parameter int BALL_SIZE = 8,
    parameter int STEP      = 4,
    parameter int PADDLE_Y  = 460,
    parameter int PADDLE_W  = 64,
    parameter int SERVE_Y   = 16
) (
    input  logic       clk_in,
    input  logic       rst,
    input  logic       tick_in,
    input  logic       serve,
    input  logic [9:0] paddle_x,
    output logic [9:0] ball_x,
    output logic [9:0] ball_y,
    output logic       in_play,
    output logic       hit_pulse,
    output logic       miss_pulse,
    output logic [7:0] hit_count
);

    typedef enum logic [1:0] {IDLE, SERVE, PLAY, MISS} state_t;

    // All geometry is compared in 11 bits so ball+STEP can never wrap.
    localparam logic [10:0] X_MAX    = 11'(H_RES - BALL_SIZE);
    localparam logic [10:0] P_LINE   = 11'(PADDLE_Y - BALL_SIZE);
    localparam logic [10:0] FLOOR_Y  = 11'(V_RES - BALL_SIZE);
    localparam logic [10:0] STEP11   = 11'(STEP);
    localparam logic [10:0] SIZE11   = 11'(BALL_SIZE);
    localparam logic [10:0] PAD_W11  = 11'(PADDLE_W);
    localparam logic [9:0]  X_SERVE  = 10'((H_RES - BALL_SIZE) / 2);
    localparam logic [9:0]  Y_SERVE  = 10'(SERVE_Y);

    state_t      state, state_nxt;
    logic        s1, s2, s3;
    logic        rise;
    logic        dir_x, dir_x_nxt;   // 1 = moving right
    logic        dir_y, dir_y_nxt;   // 1 = moving down
    logic [9:0]  x_nxt, y_nxt;
    logic [7:0]  hc_nxt;
    logic        hit_nxt, miss_nxt;
    logic [10:0] bx, by, px;
    logic        paddle_overlap;

    // Three-flop chain: two for metastability, the third for edge detection.
    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= tick_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise = s2 & ~s3;

    assign bx = {1'b0, ball_x};
    assign by = {1'b0, ball_y};
    assign px = {1'b0, paddle_x};

    // Overlap uses the pre-update x, so the hit decision matches what was drawn.
    assign paddle_overlap = (bx + SIZE11 > px) && (bx < px + PAD_W11);

    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            ball_x     <= X_SERVE;
            ball_y     <= Y_SERVE;
            dir_x      <= 1'b1;
            dir_y      <= 1'b1;
            hit_count  <= 8'd0;
            hit_pulse  <= 1'b0;
            miss_pulse <= 1'b0;
        end else begin
            state      <= state_nxt;
            ball_x     <= x_nxt;
            ball_y     <= y_nxt;
            dir_x      <= dir_x_nxt;
            dir_y      <= dir_y_nxt;
            hit_count  <= hc_nxt;
            hit_pulse  <= hit_nxt;
            miss_pulse <= miss_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        x_nxt     = ball_x;
        y_nxt     = ball_y;
        dir_x_nxt = dir_x;
        dir_y_nxt = dir_y;
        hc_nxt    = hit_count;
        hit_nxt   = 1'b0;
        miss_nxt  = 1'b0;

        case (state)
            IDLE, MISS: begin
                // Entering SERVE re-arms the ball; hit_count survives MISS until then.
                if (serve) begin
                    state_nxt = SERVE;
                    x_nxt     = X_SERVE;
                    y_nxt     = Y_SERVE;
                    dir_x_nxt = 1'b1;
                    dir_y_nxt = 1'b1;
                    hc_nxt    = 8'd0;
                end
            end
            SERVE: begin
                if (rise) state_nxt = PLAY;
            end
            PLAY: begin
                if (rise) begin
                    // Horizontal axis: walls clamp and reverse.
                    if (dir_x) begin
                        if (bx + STEP11 >= X_MAX) begin
                            x_nxt     = X_MAX[9:0];
                            dir_x_nxt = 1'b0;
                        end else begin
                            x_nxt = 10'(bx + STEP11);
                        end
                    end else begin
                        if (bx <= STEP11) begin
                            x_nxt     = 10'd0;
                            dir_x_nxt = 1'b1;
                        end else begin
                            x_nxt = 10'(bx - STEP11);
                        end
                    end

                    // Vertical axis: ceiling, paddle line crossing, floor.
                    if (!dir_y) begin
                        if (by <= STEP11) begin
                            y_nxt     = 10'd0;
                            dir_y_nxt = 1'b1;
                        end else begin
                            y_nxt = 10'(by - STEP11);
                        end
                    end else if ((by < P_LINE) && (by + STEP11 >= P_LINE) && paddle_overlap) begin
                        y_nxt     = P_LINE[9:0];
                        dir_y_nxt = 1'b0;
                        hit_nxt   = 1'b1;
                        if (hit_count != 8'hFF) hc_nxt = hit_count + 8'd1;
                    end else if ((by >= P_LINE) && (by + STEP11 >= FLOOR_Y)) begin
                        y_nxt     = FLOOR_Y[9:0];
                        miss_nxt  = 1'b1;
                        state_nxt = MISS;
                    end else begin
                        y_nxt = 10'(by + STEP11);
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign in_play = (state == PLAY);

endmodule

// File: tb/tb_ball_motion.sv
// Bench for ball_motion: directed rally vectors checked through an expected-response queue,
// plus a small-court second instance used to drive hit_count into saturation.
module tb_ball_motion;

    logic       clk_in = 1'b0;
    logic       rst;
    logic       tick_in, serve;
    logic [9:0] paddle_x;
    logic [9:0] ball_x, ball_y;
    logic       in_play, hit_pulse, miss_pulse;
    logic [7:0] hit_count;

    logic       tick2, serve2;
    logic [9:0] paddle_x2;
    logic [9:0] ball_x2, ball_y2;
    logic       in_play2, hit_pulse2, miss_pulse2;
    logic [7:0] hit_count2;

    int total = 0;
    int bad   = 0;

    always #5 clk_in = ~clk_in;

    ball_motion dut (
        .clk_in(clk_in), .rst(rst), .tick_in(tick_in), .serve(serve), .paddle_x(paddle_x),
        .ball_x(ball_x), .ball_y(ball_y), .in_play(in_play), .hit_pulse(hit_pulse),
        .miss_pulse(miss_pulse), .hit_count(hit_count)
    );

    // Short court with a full-width paddle: one paddle hit every 12 moves.
    ball_motion #(
        .H_RES(640), .V_RES(40), .BALL_SIZE(8), .STEP(4),
        .PADDLE_Y(32), .PADDLE_W(640), .SERVE_Y(4)
    ) dut_sat (
        .clk_in(clk_in), .rst(rst), .tick_in(tick2), .serve(serve2), .paddle_x(paddle_x2),
        .ball_x(ball_x2), .ball_y(ball_y2), .in_play(in_play2), .hit_pulse(hit_pulse2),
        .miss_pulse(miss_pulse2), .hit_count(hit_count2)
    );

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       ip;
        logic       hp;
        logic       mp;
        logic [7:0] hc;
    } exp_t;

    exp_t q[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, expv);
        end
    endtask

    // Reference view of when a step is due: three-stage sampling of tick_in.
    logic m1, m2, m3;
    always @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            m1 <= 1'b0; m2 <= 1'b0; m3 <= 1'b0;
        end else begin
            m1 <= tick_in; m2 <= m1; m3 <= m2;
        end
    end

    // Monitor: one edge after a detected rise the outputs must equal the queue head;
    // any pulse must be gone one cycle later.
    bit   pend = 0;
    bit   pulse_chk = 0;
    int   upd_n = 0;
    exp_t e;
    always @(negedge clk_in) begin
        if (pulse_chk) chk("pulse_width", {30'd0, hit_pulse, miss_pulse}, 32'd0);
        pulse_chk = 0;
        if (pend) begin
            upd_n++;
            total++;
            if (q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_update#%0d: x=%0d y=%0d with no expectation queued", upd_n, ball_x, ball_y);
            end else begin
                e = q.pop_front();
                if ({ball_x, ball_y, in_play, hit_pulse, miss_pulse, hit_count} !== e) begin
                    bad++;
                    $display("FAIL upd#%0d: got x=%0d y=%0d ip=%0d hp=%0d mp=%0d hc=%0d want x=%0d y=%0d ip=%0d hp=%0d mp=%0d hc=%0d",
                             upd_n, ball_x, ball_y, in_play, hit_pulse, miss_pulse, hit_count,
                             e.x, e.y, e.ip, e.hp, e.mp, e.hc);
                end
                pulse_chk = e.hp | e.mp;
            end
        end
        pend = m2 & ~m3;
    end

    // Hand-derived trajectory: right from 316 reaches 632 at move 79, then heads left.
    function automatic logic [9:0] ex(input int n);
        if (n <= 79) return 10'(316 + 4 * n);
        return 10'(632 - 4 * (n - 79));
    endfunction

    function automatic logic [9:0] ey_hit(input int n);
        if (n <= 108) return 10'(16 + 4 * n);
        if (n == 109) return 10'd452;
        return 10'(452 - 4 * (n - 109));
    endfunction

    function automatic logic [9:0] ey_miss(input int n);
        if (n <= 113) return 10'(16 + 4 * n);
        return 10'd472;
    endfunction

    task automatic tick_push(input logic [9:0] x, input logic [9:0] y, input logic ip,
                             input logic hp, input logic mp, input logic [7:0] hc);
        q.push_back({x, y, ip, hp, mp, hc});
        tick_in = 1'b1;
        repeat (2) @(negedge clk_in);
        tick_in = 1'b0;
        repeat (3) @(negedge clk_in);
    endtask

    task automatic serve_pulse();
        serve = 1'b1;
        @(negedge clk_in);
        serve = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int nh;

    initial begin
        rst = 1'b0; tick_in = 1'b0; serve = 1'b0; paddle_x = 10'd480;
        tick2 = 1'b0; serve2 = 1'b0; paddle_x2 = 10'd0;
        repeat (2) @(negedge clk_in);
        chk("rst_x", ball_x, 316);
        chk("rst_y", ball_y, 16);
        chk("rst_ip", in_play, 0);
        chk("rst_pulses", {hit_pulse, miss_pulse}, 0);
        chk("rst_hc", hit_count, 0);
        rst = 1'b1;
        @(negedge clk_in);

        // Serve, then the first tick only enters PLAY.
        serve_pulse();
        chk("serve_ip", in_play, 0);
        tick_push(10'd316, 10'd16, 1, 0, 0, 8'd0);

        // Move 1 from a tick held high for 100 cycles: exactly one step.
        q.push_back({10'd320, 10'd20, 1'b1, 1'b0, 1'b0, 8'd0});
        tick_in = 1'b1;
        repeat (100) @(negedge clk_in);
        chk("held_x", ball_x, 320);
        chk("held_y", ball_y, 20);
        tick_in = 1'b0;
        repeat (3) @(negedge clk_in);

        // Serve during PLAY is ignored.
        serve_pulse();
        @(negedge clk_in);
        chk("play_serve_x", ball_x, 320);
        chk("play_serve_ip", in_play, 1);

        // Wall bounce at move 79/80, paddle hit at move 109, rebound at 110.
        for (int n = 2; n <= 110; n++)
            tick_push(ex(n), ey_hit(n), 1, (n == 109), 0, (n >= 109) ? 8'd1 : 8'd0);

        // Asynchronous reset in the middle of the rally.
        #2 rst = 1'b0;
        #1;
        chk("midrst_x", ball_x, 316);
        chk("midrst_y", ball_y, 16);
        chk("midrst_ip", in_play, 0);
        chk("midrst_hc", hit_count, 0);
        chk("midrst_pulses", {hit_pulse, miss_pulse}, 0);
        @(negedge clk_in);
        rst = 1'b1;
        @(negedge clk_in);

        // Miss: paddle away from the ball.
        paddle_x = 10'd0;
        serve_pulse();
        tick_push(10'd316, 10'd16, 1, 0, 0, 8'd0);
        for (int n = 1; n <= 114; n++)
            tick_push(ex(n), ey_miss(n), (n < 114), 0, (n == 114), 8'd0);
        repeat (3) tick_push(ex(114), 10'd472, 0, 0, 0, 8'd0);

        // Serve from MISS reloads the serve position.
        serve_pulse();
        chk("reserve_x", ball_x, 316);
        chk("reserve_y", ball_y, 16);
        chk("reserve_ip", in_play, 0);
        chk("queue_drained", q.size(), 0);

        // Saturation on the short court.
        serve2 = 1'b1;
        @(negedge clk_in);
        serve2 = 1'b0;
        tick2 = 1'b1; repeat (2) @(negedge clk_in); tick2 = 1'b0; repeat (3) @(negedge clk_in);
        chk("sat_play", in_play2, 1);
        nh = 0;
        for (int t = 0; t < 4000 && nh < 256; t++) begin
            tick2 = 1'b1;
            repeat (2) @(negedge clk_in);
            tick2 = 1'b0;
            @(negedge clk_in);
            if (hit_pulse2) begin
                nh++;
                chk("sat_hc", hit_count2, (nh > 255) ? 255 : nh);
            end
            if (nh < 256) repeat (2) @(negedge clk_in);
        end
        chk("sat_hits", nh, 256);
        chk("sat_y", ball_y2, 24);

        // Reset while the 256th hit pulse is high.
        #1 rst = 1'b0;
        #1;
        chk("pulse_rst_hp", hit_pulse2, 0);
        chk("pulse_rst_mp", miss_pulse2, 0);
        chk("pulse_rst_hc", hit_count2, 0);
        chk("pulse_rst_ip", in_play2, 0);
        chk("pulse_rst_x", ball_x2, 316);
        @(negedge clk_in);
        rst = 1'b1;
        repeat (2) @(negedge clk_in);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ball_motion.md
# ball_motion

Ball-position engine for the squash court. It consumes the slow game tick from the clock divider as `tick_in`, synchronises it into the `clk_in` domain, and advances the ball once per tick. Each update handles wall bounces, the paddle hit/miss decision and rally bookkeeping. Its outputs drive the VGA renderer and the score logic downstream.

## Interface
- `H_RES`, 640: court width in pixels.
- `V_RES`, 480: court height in pixels.
- `BALL_SIZE`, 8: ball edge length in pixels.
- `STEP`, 4: pixels moved per tick on each axis.
- `PADDLE_Y`, 460: y of the paddle top edge.
- `PADDLE_W`, 64: paddle width.
- `SERVE_Y`, 16: ball y after a serve.
- `clk_in` input 1: system clock; all state is on its rising edge.
- `rst` input 1: reset, asynchronous, active-low.
- `tick_in` input 1: divided game clock; treated as asynchronous, rising edge = one step.
- `serve` input 1: level, sampled each `clk_in`; starts a rally.
- `paddle_x` input 10: paddle left edge, unsigned.
- `ball_x` output 10: ball left edge.
- `ball_y` output 10: ball top edge.
- `in_play` output 1: high in PLAY only.
- `hit_pulse` output 1: one-cycle pulse on a paddle hit.
- `miss_pulse` output 1: one-cycle pulse on reaching the floor.
- `hit_count` output 8: hits in the current rally, saturates at 255.

## Operation
- Reset values: state IDLE; `ball_x` = (H_RES-BALL_SIZE)/2 = 316; `ball_y` = SERVE_Y; `dir_x` = right; `dir_y` = down; all pulses 0; `in_play` 0; `hit_count` 0; synchroniser flops 0.
- Tick detection:
  - s1<=tick_in; s2<=s1; s3<=s2; rise = s2 & ~s3.
  - A held-high `tick_in` produces exactly one rise.
- States:
  - IDLE: on `serve`=1, go to SERVE.
  - SERVE: on entry, load the serve position, set dir right/down, clear `hit_count`. On the next rise go to PLAY without moving.
  - PLAY: on each rise, apply the update rules below.
  - MISS: hold the ball; on `serve`=1, go to SERVE.
  - `serve` is ignored in SERVE and PLAY.
- Update rules. X and Y are evaluated from the pre-update values in the same cycle; a corner bounces on both axes in one tick.
  - Right wall: if moving right and ball_x+STEP >= H_RES-BALL_SIZE, set ball_x = H_RES-BALL_SIZE and dir_x = left.
  - Left wall: if moving left and ball_x <= STEP, set ball_x = 0 and dir_x = right.
  - Ceiling: if moving up and ball_y <= STEP, set ball_y = 0 and dir_y = down.
  - Otherwise each axis moves by ±STEP.
- Paddle line, P = PADDLE_Y-BALL_SIZE:
  - Checked when moving down with ball_y < P and ball_y+STEP >= P.
  - Hit when ball_x+BALL_SIZE > paddle_x and ball_x < paddle_x+PADDLE_W, using the pre-update ball_x.
  - On a hit: ball_y = P, dir_y = up, `hit_pulse`, `hit_count`+1 (saturating).
  - On a miss: normal advance. Once ball_y >= P the check never fires again.
- Floor, F = V_RES-BALL_SIZE: if moving down, ball_y >= P and ball_y+STEP >= F, set ball_y = F, assert `miss_pulse`, go to MISS.
- `hit_count` holds through MISS so the score logic can read it.
- Arithmetic: all compares in 11-bit unsigned, so no wrap is possible. `paddle_x` must be stable during the rise cycle; no range check is done on it.

## Timing
- `tick_in` high before clk edge 1 gives rise during the cycle after edge 2. The position, pulses and state are registered at edge 3.
- The minimum `tick_in` high or low time is 2 `clk_in` periods. Shorter pulses may be lost.
- `hit_pulse` and `miss_pulse` go high at the same edge as the position update and last exactly one cycle.
- Serve → SERVE takes 1 edge. SERVE → PLAY happens at the next rise edge. `in_play` rises with the PLAY entry and falls at the MISS edge.
- `rst` low forces reset values immediately, independent of the clock, including mid-rally and mid-pulse. Release is synchronous to the next edge.

## Test plan
- **Reset:** `rst`=0 mid-PLAY → immediately `ball_x`=316, `ball_y`=16, `in_play`=0, `hit_count`=0, no pulses.
- **Serve and wall bounce:** `serve`, then 1 tick (PLAY), then 79 ticks → `ball_x`=632 with dir left, `ball_y`=332. Tick 80 → `ball_x`=628.
- **Paddle hit:** serve, `paddle_x`=480, 109 moving ticks. At move 109 the pre-update `ball_x` is 516 → `ball_y`=452, `ball_x`=512, one-cycle `hit_pulse`, `hit_count`=1. Next tick → `ball_y`=448.
- **Miss:** as the hit case with `paddle_x`=0 → move 109 gives `ball_y`=452 with no pulse. Moves 110..113 give 456..468. Move 114 → `ball_y`=472, `miss_pulse`, state MISS, `in_play`=0. Further ticks produce no change.
- **Tick hygiene:**
  - `tick_in` held high for 100 cycles → exactly one step, landing at the 3rd edge.
  - `serve` pulsed during PLAY → no effect.
- **Saturation:** force `hit_count` to 255 via repeated hits → another hit keeps it at 255 and still pulses.
